pulse_processing_top: RTL and testbench

//  Post-ADC pulse-fit stage. Pulls a fixed 16-sample window from the preprocessing FIFO.

---
 rtl/pulse_processing_top.sv | 151 +++++++++++++++
 tb/tb_pulse_processing_top.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_processing_top.sv
// Pulse-fit stage: reads a 16-sample window from the ADC FIFO and reports peak amplitude,
// sub-sample peak position (parabolic interpolation) and a flat-top residual.
//
// state  | meaning
// IDLE   | wait for a full window in the FIFO
// READ   | rd_en high for NSAMP cycles, samples captured one cycle behind
// DRAIN  | rd_en low, last sample captured
// PREP   | form interpolation numerator/denominator and residual
// DIV    | 4-step restoring divide for the fractional offset
// UPDATE | publish results
module pulse_processing_top #(
  parameter int NSAMP     = 16,
  parameter int FRAC_BITS = 4
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  output logic        fifo_adc_rd_en_p,
  input  logic [9:0]  fifo_adc_data_count_p,
  input  logic [79:0] fifo_adc_dout_p,
  output logic [15:0] result_a,
  output logic [7:0]  result_c,
  output logic [20:0] error
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, PREP, DIV, UPDATE} state_t;

  state_t      state;
  logic [3:0]  rd_cnt;
  logic        vld;
  logic [3:0]  cap_idx;
  logic [15:0] samp [16];
  logic [19:0] sum;
  logic [15:0] max_val;
  logic [3:0]  max_idx;
  logic [21:0] rem;
  logic [21:0] dvs;
  logic [3:0]  q;
  logic [1:0]  div_cnt;
  logic        neg;
  logic        zero_frac;
  logic [20:0] err_q;

  logic [15:0] adc;
  logic [15:0] ym;
  logic [15:0] yp;
  logic [16:0] absd;
  logic [17:0] den;
  logic        edge_pk;
  logic [20:0] err_c;
  logic [7:0]  frac8;
  logic        unused_ts;

  assign adc       = fifo_adc_dout_p[15:0];
  assign unused_ts = ^fifo_adc_dout_p[79:16];

  // Neighbour indices may wrap at the window edges; those cases are forced to frac=0.
  always_comb begin
    ym      = samp[max_idx - 4'd1];
    yp      = samp[max_idx + 4'd1];
    absd    = (ym >= yp) ? (17'(ym) - 17'(yp)) : (17'(yp) - 17'(ym));
    den     = {1'b0, max_val, 1'b0} - 18'(ym) - 18'(yp);
    edge_pk = (max_idx == 4'd0) || (max_idx == 4'(NSAMP - 1));
    err_c   = (21'(max_val) * 21'(NSAMP)) - 21'(sum);
    frac8   = 8'd0;
    if (!zero_frac) frac8 = neg ? (8'd0 - {4'd0, q}) : {4'd0, q};
  end

  always_ff @(posedge clk210_p or negedge reset_p) begin
    if (!reset_p) begin
      state            <= IDLE;
      fifo_adc_rd_en_p <= 1'b0;
      rd_cnt           <= '0;
      vld              <= 1'b0;
      cap_idx          <= '0;
      for (int i = 0; i < 16; i++) samp[i] <= '0;
      sum              <= '0;
      max_val          <= '0;
      max_idx          <= '0;
      rem              <= '0;
      dvs              <= '0;
      q                <= '0;
      div_cnt          <= '0;
      neg              <= 1'b0;
      zero_frac        <= 1'b0;
      err_q            <= '0;
      result_a         <= '0;
      result_c         <= '0;
      error            <= '0;
    end else begin
      // FIFO is standard-read: data for an rd_en cycle is valid the following cycle.
      vld <= fifo_adc_rd_en_p;
      if (vld) begin
        samp[cap_idx] <= adc;
        sum           <= ((cap_idx == 4'd0) ? 20'd0 : sum) + 20'(adc);
        if (cap_idx == 4'd0 || adc > max_val) begin
          max_val <= adc;
          max_idx <= cap_idx;
        end
        cap_idx <= cap_idx + 4'd1;
      end

      case (state)
        IDLE: begin
          if (fifo_adc_data_count_p >= 10'(NSAMP)) begin
            state            <= READ;
            fifo_adc_rd_en_p <= 1'b1;
            rd_cnt           <= '0;
            cap_idx          <= '0;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + 4'd1;
          if (rd_cnt == 4'(NSAMP - 1)) begin
            fifo_adc_rd_en_p <= 1'b0;
            state            <= DRAIN;
          end
        end
        DRAIN: state <= PREP;
        PREP: begin
          zero_frac <= edge_pk || (den == 18'd0);
          neg       <= ym > yp;
          rem       <= 22'({absd, 3'b000});
          dvs       <= 22'({den, 3'b000});
          q         <= '0;
          div_cnt   <= '0;
          err_q     <= err_c;
          state     <= DIV;
        end
        DIV: begin
          if (rem >= dvs) begin
            rem <= rem - dvs;
            q   <= {q[2:0], 1'b1};
          end else begin
            q   <= {q[2:0], 1'b0};
          end
          dvs     <= dvs >> 1;
          div_cnt <= div_cnt + 2'd1;
          if (div_cnt == 2'd3) state <= UPDATE;
        end
        UPDATE: begin
          result_a <= max_val;
          result_c <= (8'(max_idx) << FRAC_BITS) + frac8;
          error    <= err_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_processing_top.sv
// Bench for pulse_processing_top: FIFO model, directed windows and randomized windows
// compared against a plain-arithmetic reference of the pulse fit.
`timescale 1ns/1ps
module tb_pulse_processing_top;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        rd_en;
  logic [9:0]  count;
  logic [79:0] dout;
  logic [15:0] result_a;
  logic [7:0]  result_c;
  logic [20:0] error;

  always #2 clk = ~clk;

  pulse_processing_top dut (
    .clk210_p              (clk),
    .reset_p               (reset_p),
    .fifo_adc_rd_en_p      (rd_en),
    .fifo_adc_data_count_p (count),
    .fifo_adc_dout_p       (dout),
    .result_a              (result_a),
    .result_c              (result_c),
    .error                 (error)
  );

  logic [15:0] fifo_q [$];
  int          rd_pulses = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_a = '0;
  logic [7:0]  exp_c = '0;
  logic [20:0] exp_e = '0;

  // Standard-read FIFO: data appears the cycle after rd_en, random timestamp bits.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_pulses = rd_pulses + 1;
      if (fifo_q.size() > 0) dout <= {32'($urandom), 32'($urandom), fifo_q.pop_front()};
      else                   dout <= {32'($urandom), 32'($urandom), 16'hdead};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model(input logic [15:0] w [16], output logic [15:0] a,
                       output logic [7:0] c, output logic [20:0] e);
    int p, y0, sum, ym, yp, num, den, q, frac;
    p = 0; y0 = int'(w[0]); sum = 0;
    for (int i = 0; i < 16; i++) begin
      sum += int'(w[i]);
      if (int'(w[i]) > y0) begin y0 = int'(w[i]); p = i; end
    end
    frac = 0;
    if (p > 0 && p < 15) begin
      ym  = int'(w[p-1]);
      yp  = int'(w[p+1]);
      num = 8 * (ym - yp);
      den = 2 * y0 - ym - yp;
      if (den != 0) begin
        q    = ((num < 0) ? -num : num) / den;
        frac = (num > 0) ? -q : q;
      end
    end
    a = 16'(y0);
    c = 8'(p * 16 + frac);
    e = 21'(16 * y0 - sum);
  endtask

  task automatic run_window(input logic [15:0] w [16], input string tag, input bit hold);
    logic [15:0] a; logic [7:0] c; logic [20:0] e;
    bit seen;
    for (int i = 0; i < 16; i++) fifo_q.push_back(w[i]);
    rd_pulses = 0;
    count = 10'd16;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = rd_en;
    end
    check({tag, "_start"}, 32'(seen), 32'd1);
    if (!seen) return;
    if (!hold) count = 10'($urandom_range(0, 15));
    model(w, a, c, e);
    repeat (22) @(negedge clk);
    check({tag, "_hold_a"}, 32'(result_a), 32'(exp_a));
    check({tag, "_hold_e"}, 32'(error), 32'(exp_e));
    @(negedge clk);
    check({tag, "_a"}, 32'(result_a), 32'(a));
    check({tag, "_c"}, 32'(result_c), 32'(c));
    check({tag, "_e"}, 32'(error), 32'(e));
    check({tag, "_rdcnt"}, 32'(rd_pulses), 32'd16);
    check({tag, "_rdlow"}, 32'(rd_en), 32'd0);
    exp_a = a; exp_c = c; exp_e = e;
  endtask

  task automatic gen_window(output logic [15:0] w [16]);
    int mode, pk, amp, d, v;
    mode = $urandom_range(0, 2);
    pk   = $urandom_range(0, 15);
    amp  = $urandom_range(20000, 60000);
    d    = $urandom_range(0, 1200);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       v = $urandom_range(0, 65535);
        1:       v = $urandom_range(1000, 1003);
        default: v = amp - d * ((i > pk) ? i - pk : pk - i) - $urandom_range(0, 50);
      endcase
      w[i] = 16'(v);
    end
  endtask

  logic [15:0] win [16];
  logic [15:0] win2 [16];
  int          base;
  bit          seen6;

  initial begin
    reset_p = 1'b0;
    count   = 10'd18;
    dout    = '0;
    repeat (5) begin
      @(negedge clk);
      check("rst_rd_en", 32'(rd_en), 32'd0);
    end
    check("rst_a", 32'(result_a), 32'd0);
    check("rst_c", 32'(result_c), 32'd0);
    check("rst_e", 32'(error), 32'd0);
    count = 10'd0;
    @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);

    win = '{16'd5166, 16'd5668, 16'd6142, 16'd6570, 16'd6936, 16'd7224, 16'd7448, 16'd7598,
            16'd7686, 16'd7726, 16'd7740, 16'd7684, 16'd7594, 16'd7494, 16'd7354, 16'd7190};
    run_window(win, "vec", 1'b0);
    check("vec_a_const", 32'(result_a), 32'd7740);
    check("vec_c_const", 32'(result_c), 32'd156);
    check("vec_e_const", 32'(error), 32'd10620);

    for (int i = 0; i < 16; i++) win[i] = 16'd7190;
    run_window(win, "flat", 1'b0);
    check("flat_c_const", 32'(result_c), 32'd0);
    check("flat_e_const", 32'(error), 32'd0);

    count = 10'd15;
    rd_pulses = 0;
    repeat (40) @(negedge clk);
    check("cnt15_no_rd", 32'(rd_pulses), 32'd0);
    gen_window(win);
    run_window(win, "cnt16", 1'b0);

    for (int i = 0; i < 16; i++) win[i] = 16'(100 * (i + 1));
    run_window(win, "ramp", 1'b0);
    check("ramp_c_const", 32'(result_c), 32'd240);
    check("ramp_e_const", 32'(error), 32'd12000);

    // Reset on the 8th rd_en cycle of a window.
    gen_window(win);
    for (int i = 0; i < 16; i++) fifo_q.push_back(win[i]);
    count = 10'd16;
    seen6 = 1'b0;
    for (int k = 0; k < 40 && !seen6; k++) begin
      @(negedge clk);
      seen6 = rd_en;
    end
    check("abort_start", 32'(seen6), 32'd1);
    repeat (7) @(negedge clk);
    check("abort_rd8", 32'(rd_en), 32'd1);
    reset_p = 1'b0;
    #1;
    check("abort_rd_en", 32'(rd_en), 32'd0);
    check("abort_a", 32'(result_a), 32'd0);
    check("abort_c", 32'(result_c), 32'd0);
    check("abort_e", 32'(error), 32'd0);
    exp_a = '0; exp_c = '0; exp_e = '0;
    count = 10'd0;
    fifo_q.delete();
    repeat (3) @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);
    gen_window(win);
    run_window(win, "fresh", 1'b0);

    for (int n = 0; n < 20; n++) begin
      gen_window(win);
      run_window(win, $sformatf("rnd%0d", n), 1'b0);
    end

    // Ties: plateau at two indices, the lower one must win.
    base = $urandom_range(3000, 9000);
    for (int i = 0; i < 16; i++) win[i] = 16'(base - 10 * i);
    win[4] = 16'(base + 500); win[9] = 16'(base + 500);
    run_window(win, "tie", 1'b0);

    // Back-to-back windows with occupancy held high.
    gen_window(win);
    gen_window(win2);
    run_window(win, "b2b0", 1'b1);
    run_window(win2, "b2b1", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
